alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide over operand magnitudes with a final sign fix-up.
module alu_mc #(
  parameter int N_BIT  = 32,
  parameter int FUNC_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [FUNC_W-1:0] alu_func,
  input  logic [N_BIT-1:0]  A,
  input  logic [N_BIT-1:0]  B,
  output logic              busy,
  output logic              done,
  output logic [N_BIT-1:0]  lo,
  output logic [N_BIT-1:0]  hi,
  output logic [3:0]        alu_flag
);

  localparam int unsigned CNT_W = $clog2(N_BIT);

  localparam logic [FUNC_W-1:0] OP_ADD   = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] OP_SUB   = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] OP_PASSA = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] OP_PASSB = FUNC_W'(3);
  localparam logic [FUNC_W-1:0] OP_AND   = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] OP_OR    = FUNC_W'(5);
  localparam logic [FUNC_W-1:0] OP_XOR   = FUNC_W'(6);
  localparam logic [FUNC_W-1:0] OP_SLT   = FUNC_W'(7);
  localparam logic [FUNC_W-1:0] OP_SLTU  = FUNC_W'(8);
  localparam logic [FUNC_W-1:0] OP_MULT  = FUNC_W'(9);
  localparam logic [FUNC_W-1:0] OP_MULTU = FUNC_W'(10);
  localparam logic [FUNC_W-1:0] OP_DIV   = FUNC_W'(11);
  localparam logic [FUNC_W-1:0] OP_DIVU  = FUNC_W'(12);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [N_BIT-1:0]   work_hi;
  logic [N_BIT-1:0]   work_lo;
  logic [N_BIT-1:0]   mag_b;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               ovf_pend;

  logic [N_BIT-1:0]   sum;
  logic [N_BIT-1:0]   diff;
  logic [N_BIT-1:0]   sc_lo;
  logic [N_BIT-1:0]   sc_hi;
  logic               sc_ovf;
  logic               sc_dbz;
  logic               is_mul;
  logic               is_dv;
  logic               is_sgn;
  logic               is_long;
  logic [N_BIT-1:0]   mag_a_c;
  logic [N_BIT-1:0]   mag_b_c;

  logic [N_BIT:0]     mul_sum;
  logic [N_BIT-1:0]   mul_hi_nx;
  logic [N_BIT-1:0]   mul_lo_nx;
  logic [N_BIT:0]     div_sh;
  logic               div_ge;
  logic [N_BIT-1:0]   div_hi_nx;
  logic [N_BIT-1:0]   div_lo_nx;
  logic [2*N_BIT-1:0] prod_raw;
  logic [2*N_BIT-1:0] prod_fix;
  logic [N_BIT-1:0]   fin_lo;
  logic [N_BIT-1:0]   fin_hi;

  // Single-cycle results and acceptance decode for the incoming opcode
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    sc_lo   = '0;
    sc_hi   = '0;
    sc_ovf  = 1'b0;
    sc_dbz  = 1'b0;
    is_mul  = (alu_func == OP_MULT) || (alu_func == OP_MULTU);
    is_dv   = (alu_func == OP_DIV)  || (alu_func == OP_DIVU);
    is_sgn  = (alu_func == OP_MULT) || (alu_func == OP_DIV);
    is_long = is_mul || (is_dv && (B != '0));
    mag_a_c = (is_sgn && A[N_BIT-1]) ? (N_BIT'(0) - A) : A;
    mag_b_c = (is_sgn && B[N_BIT-1]) ? (N_BIT'(0) - B) : B;
    case (alu_func)
      OP_ADD: begin
        sc_lo  = sum;
        sc_ovf = (A[N_BIT-1] == B[N_BIT-1]) && (sum[N_BIT-1] != A[N_BIT-1]);
      end
      OP_SUB: begin
        sc_lo  = diff;
        sc_ovf = (A[N_BIT-1] != B[N_BIT-1]) && (diff[N_BIT-1] != A[N_BIT-1]);
      end
      OP_PASSA: sc_lo = A;
      OP_PASSB: sc_lo = B;
      OP_AND:   sc_lo = A & B;
      OP_OR:    sc_lo = A | B;
      OP_XOR:   sc_lo = A ^ B;
      OP_SLT:   sc_lo = N_BIT'($signed(A) < $signed(B));
      OP_SLTU:  sc_lo = N_BIT'(A < B);
      OP_DIV, OP_DIVU: begin
        // Only reached as a single-cycle op when the divisor is zero
        sc_lo  = '1;
        sc_hi  = A;
        sc_dbz = 1'b1;
      end
      default: begin
        sc_lo = '0;
        sc_hi = '0;
      end
    endcase
  end

  // One iteration of shift-add multiply / restoring divide plus sign fix-up
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_b} : '0);
    mul_hi_nx = mul_sum[N_BIT:1];
    mul_lo_nx = {mul_sum[0], work_lo[N_BIT-1:1]};
    div_sh    = {work_hi, work_lo[N_BIT-1]};
    div_ge    = div_sh >= {1'b0, mag_b};
    div_hi_nx = div_ge ? N_BIT'(div_sh - {1'b0, mag_b}) : div_sh[N_BIT-1:0];
    div_lo_nx = {work_lo[N_BIT-2:0], div_ge};
    prod_raw  = {mul_hi_nx, mul_lo_nx};
    prod_fix  = neg_q ? ((2*N_BIT)'(0) - prod_raw) : prod_raw;
    if (op_div) begin
      fin_lo = neg_q ? (N_BIT'(0) - div_lo_nx) : div_lo_nx;
      fin_hi = neg_r ? (N_BIT'(0) - div_hi_nx) : div_hi_nx;
    end else begin
      fin_lo = prod_fix[N_BIT-1:0];
      fin_hi = prod_fix[2*N_BIT-1:N_BIT];
    end
  end

  // Control FSM, iteration datapath and registered results
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      lo       <= '0;
      hi       <= '0;
      alu_flag <= '0;
      count    <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      mag_b    <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          count   <= count + CNT_W'(1);
          work_hi <= op_div ? div_hi_nx : mul_hi_nx;
          work_lo <= op_div ? div_lo_nx : mul_lo_nx;
          if (count == CNT_W'(N_BIT - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            lo       <= fin_lo;
            hi       <= fin_hi;
            alu_flag <= {1'b0, ovf_pend, fin_lo[N_BIT-1], fin_lo == '0};
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            if (is_long) begin
              state    <= RUN;
              busy     <= 1'b1;
              count    <= '0;
              work_hi  <= '0;
              work_lo  <= mag_a_c;
              mag_b    <= mag_b_c;
              op_div   <= is_dv;
              neg_q    <= is_sgn && (A[N_BIT-1] ^ B[N_BIT-1]);
              neg_r    <= is_sgn && A[N_BIT-1];
              ovf_pend <= (alu_func == OP_DIV) && (A == {1'b1, {(N_BIT-1){1'b0}}})
                          && (B == '1);
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              lo       <= sc_lo;
              hi       <= sc_hi;
              alu_flag <= {sc_dbz, sc_ovf, sc_lo[N_BIT-1], sc_lo == '0};
            end
          end
        end
      endcase
    end
  end

endmodule
